// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bundle: ID instruction fields in, stall/issue
// strobes and performance/status outputs back to the pipeline.
interface hazard_scoreboard_if #(
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = 2,
   parameter int PERF_W   = 16
);
   localparam int IDX_W = $clog2(NUM_REGS);

   logic                id_valid;
   logic [IDX_W-1:0]    id_src1;
   logic                id_src1_en;
   logic [IDX_W-1:0]    id_src2;
   logic                id_src2_en;
   logic [IDX_W-1:0]    id_dst;
   logic                id_wr_en;
   logic [CNT_W-1:0]    id_lat;
   logic                flush;
   logic                clr_cnt;
   logic                stall;
   logic                issue;
   logic [NUM_REGS-1:0] busy;
   logic                idle;
   logic [PERF_W-1:0]   stall_cnt;

   modport master (
      output id_valid, id_src1, id_src1_en, id_src2, id_src2_en,
             id_dst, id_wr_en, id_lat, flush, clr_cnt,
      input  stall, issue, busy, idle, stall_cnt
   );

   modport slave (
      input  id_valid, id_src1, id_src1_en, id_src2, id_src2_en,
             id_dst, id_wr_en, id_lat, flush, clr_cnt,
      output stall, issue, busy, idle, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register wait counters that gate decode issue on RAW and WAW hazards,
// with a saturating stall-cycle performance counter.
module hazard_scoreboard #(
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = 2,
   parameter int PERF_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_scoreboard_if.slave   sb
);
   logic [CNT_W-1:0]    cnt_r [NUM_REGS];
   logic [PERF_W-1:0]   stall_cnt_r;
   logic                h1_s;
   logic                h2_s;
   logic                hw_s;
   logic                stall_s;
   logic                issue_s;
   logic                load_s;
   logic [NUM_REGS-1:0] busy_s;

   // Hazard detection from registered counters only; strobes held low in reset.
   always_comb begin
      h1_s    = sb.id_src1_en & (cnt_r[sb.id_src1] != {CNT_W{1'b0}});
      h2_s    = sb.id_src2_en & (cnt_r[sb.id_src2] != {CNT_W{1'b0}});
      hw_s    = sb.id_wr_en & (sb.id_dst != {$bits(sb.id_dst){1'b0}}) &
                (cnt_r[sb.id_dst] > sb.id_lat);
      stall_s = rst_n & sb.id_valid & ~sb.flush & (h1_s | h2_s | hw_s);
      issue_s = rst_n & sb.id_valid & ~sb.flush & ~stall_s;
      load_s  = issue_s & sb.id_wr_en;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_s[r] = (cnt_r[r] != {CNT_W{1'b0}});
      end
   end

   // Wait counters: an issuing writer reloads its destination, all others drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_r[r] <= {CNT_W{1'b0}};
         end
      end else begin
         cnt_r[0] <= {CNT_W{1'b0}};
         for (int r = 1; r < NUM_REGS; r++) begin
            if (load_s && (sb.id_dst == r[$bits(sb.id_dst)-1:0])) begin
               cnt_r[r] <= sb.id_lat;
            end else if (cnt_r[r] != {CNT_W{1'b0}}) begin
               cnt_r[r] <= cnt_r[r] - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_r[r] <= cnt_r[r];
            end
         end
      end
   end

   // Stall-cycle counter: clear wins, otherwise saturating increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {PERF_W{1'b0}};
      end else if (sb.clr_cnt) begin
         stall_cnt_r <= {PERF_W{1'b0}};
      end else if (stall_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign sb.stall     = stall_s;
   assign sb.issue     = issue_s;
   assign sb.busy      = busy_s;
   assign sb.idle      = ~|busy_s;
   assign sb.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: expected responses queued at
// drive time and compared by an independent negedge monitor.
module tb_hazard_scoreboard;
   logic clk;
   logic rst_n;

   hazard_scoreboard_if #(.NUM_REGS(16), .CNT_W(2), .PERF_W(16)) sb_if ();

   hazard_scoreboard #(.NUM_REGS(16), .CNT_W(2), .PERF_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb_if.slave)
   );

   typedef struct {
      logic        stall;
      logic        issue;
      logic [15:0] busy;
      logic [15:0] scnt;
   } exp_t;

   exp_t  exp_q  [$];
   string name_q [$];
   int    checks   = 0;
   int    failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [3:0] s1, input logic s1e,
                        input logic [3:0] s2, input logic s2e, input logic [3:0] d,
                        input logic we, input logic [1:0] lat, input logic fl,
                        input logic clr);
      sb_if.id_valid   = v;
      sb_if.id_src1    = s1;
      sb_if.id_src1_en = s1e;
      sb_if.id_src2    = s2;
      sb_if.id_src2_en = s2e;
      sb_if.id_dst     = d;
      sb_if.id_wr_en   = we;
      sb_if.id_lat     = lat;
      sb_if.flush      = fl;
      sb_if.clr_cnt    = clr;
   endtask

   task automatic expect_now(input string name, input logic st, input logic is,
                             input logic [15:0] bz, input logic [15:0] sc);
      exp_t e;
      e.stall = st;
      e.issue = is;
      e.busy  = bz;
      e.scnt  = sc;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input string field,
                      input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
      end
   endtask

   // Monitor: pop and compare whenever an expectation is pending this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         cmp(n, "stall",     {15'd0, sb_if.stall}, {15'd0, e.stall});
         cmp(n, "issue",     {15'd0, sb_if.issue}, {15'd0, e.issue});
         cmp(n, "busy",      sb_if.busy,           e.busy);
         cmp(n, "idle",      {15'd0, sb_if.idle},  {15'd0, (e.busy == 16'h0000)});
         cmp(n, "stall_cnt", sb_if.stall_cnt,      e.scnt);
      end
   end

   initial begin
      int          k;
      int          nstall;
      logic        st;
      logic [15:0] mscnt;

      rst_n = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 2'd3, 1'b0, 1'b0);
      expect_now("reset_hold", 1'b0, 1'b0, 16'h0000, 16'd0);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("first_issue", 1'b0, 1'b1, 16'h0000, 16'd0);

      // Load-use
      tick(); drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 2'd1, 1'b0, 1'b0);
      expect_now("load_r4", 1'b0, 1'b1, 16'h0000, 16'd0);
      tick(); drive(1'b1, 4'd4, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("use_r4_stall", 1'b1, 1'b0, 16'h0010, 16'd0);
      tick();
      expect_now("use_r4_issue", 1'b0, 1'b1, 16'h0000, 16'd1);

      // ALU back-to-back and r0
      tick(); drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("alu_r6", 1'b0, 1'b1, 16'h0000, 16'd1);
      tick(); drive(1'b1, 4'd6, 1'b1, 4'd6, 1'b1, 4'd7, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("use_r6_b2b", 1'b0, 1'b1, 16'h0000, 16'd1);
      tick(); drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      expect_now("write_r0", 1'b0, 1'b1, 16'h0000, 16'd1);
      tick(); drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      expect_now("read_r0", 1'b0, 1'b1, 16'h0000, 16'd1);

      // Flush priority
      tick(); drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 2'd1, 1'b0, 1'b0);
      expect_now("load_r7", 1'b0, 1'b1, 16'h0000, 16'd1);
      tick(); drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 2'd2, 1'b1, 1'b0);
      expect_now("flush_use_r7", 1'b0, 1'b0, 16'h0080, 16'd1);
      tick(); drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      expect_now("after_flush", 1'b0, 1'b0, 16'h0000, 16'd1);

      // Long latency and WAW
      tick(); drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 2'd3, 1'b0, 1'b0);
      expect_now("lat3_r8", 1'b0, 1'b1, 16'h0000, 16'd1);
      tick(); drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("waw_r8_s1", 1'b1, 1'b0, 16'h0100, 16'd1);
      tick(); expect_now("waw_r8_s2", 1'b1, 1'b0, 16'h0100, 16'd2);
      tick(); expect_now("waw_r8_s3", 1'b1, 1'b0, 16'h0100, 16'd3);
      tick(); expect_now("waw_r8_issue", 1'b0, 1'b1, 16'h0000, 16'd4);

      // Late consumer stalls only for the remaining count
      tick(); drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 2'd3, 1'b0, 1'b0);
      expect_now("lat3_r10", 1'b0, 1'b1, 16'h0000, 16'd4);
      tick(); drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      expect_now("gap_r10", 1'b0, 1'b0, 16'h0400, 16'd4);
      tick(); drive(1'b1, 4'd1, 1'b1, 4'd10, 1'b1, 4'd3, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("late_use_s1", 1'b1, 1'b0, 16'h0400, 16'd4);
      tick(); expect_now("late_use_s2", 1'b1, 1'b0, 16'h0400, 16'd5);
      tick(); expect_now("late_use_issue", 1'b0, 1'b1, 16'h0000, 16'd6);

      // Source equals destination
      tick(); drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 2'd2, 1'b0, 1'b0);
      expect_now("lat2_r11", 1'b0, 1'b1, 16'h0000, 16'd6);
      tick(); drive(1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 4'd11, 1'b1, 2'd2, 1'b0, 1'b0);
      expect_now("inc_r11_s1", 1'b1, 1'b0, 16'h0800, 16'd6);
      tick(); expect_now("inc_r11_s2", 1'b1, 1'b0, 16'h0800, 16'd7);
      tick(); expect_now("inc_r11_issue", 1'b0, 1'b1, 16'h0000, 16'd8);
      tick(); drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      expect_now("r11_reload_2", 1'b0, 1'b0, 16'h0800, 16'd8);
      tick(); expect_now("r11_reload_1", 1'b0, 1'b0, 16'h0800, 16'd8);

      // Reset asserted mid-stall
      tick(); drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 2'd3, 1'b0, 1'b0);
      expect_now("lat3_r12", 1'b0, 1'b1, 16'h0000, 16'd8);
      tick(); drive(1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 2'd0, 1'b0, 1'b0);
      expect_now("use_r12_stall", 1'b1, 1'b0, 16'h1000, 16'd8);
      tick(); rst_n = 1'b0;
      expect_now("mid_stall_reset", 1'b0, 1'b0, 16'h0000, 16'd0);
      tick(); rst_n = 1'b1;
      expect_now("post_reset_issue", 1'b0, 1'b1, 16'h0000, 16'd0);

      // Saturation: held r13 reload gives issue, stall, stall, stall repeating
      k = 0;
      nstall = 0;
      mscnt = 16'd0;
      while (nstall < 65540) begin
         tick();
         drive(1'b1, 4'd13, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 2'd3, 1'b0, 1'b0);
         st = ((k % 4) != 0);
         if (k < 8) begin
            expect_now("sat_pattern", st, ~st, st ? 16'h2000 : 16'h0000, mscnt);
         end
         if (st) begin
            nstall++;
            if (mscnt != 16'hFFFF) mscnt = mscnt + 16'd1;
         end
         k++;
      end
      tick();
      drive(1'b1, 4'd13, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 2'd3, 1'b0, 1'b1);
      st = ((k % 4) != 0);
      expect_now("saturated_clr", st, ~st, st ? 16'h2000 : 16'h0000, 16'hFFFF);
      tick();
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      expect_now("after_clear", 1'b0, 1'b0, 16'h0000, 16'd0);
      tick();
      tick();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage data-hazard scoreboard for the 16-bit 5-stage pipeline. It sits directly upstream of the register file read ports, alongside the IF/ID register. It tracks, per architectural register, how many more cycles a dependent instruction must wait before its operand can be read from the register file or taken from forwarding. From that it generates the decode stall and the issue strobe, and it counts stall cycles for performance monitoring.

## Interface
Parameters:
- NUM_REGS, 16, number of architectural registers (register 0 hardwired to zero)
- CNT_W, 2, width of each per-register wait counter (max latency 3)
- PERF_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- id_src1  in  4  first source register ID (same encoding as register file SrcReg1)
- id_src1_en  in  1  instruction reads id_src1
- id_src2  in  4  second source register ID
- id_src2_en  in  1  instruction reads id_src2
- id_dst  in  4  destination register ID
- id_wr_en  in  1  instruction writes id_dst
- id_lat  in  2  stall cycles a back-to-back consumer needs (0 = ALU with forwarding, 1 = load)
- flush  in  1  cancel instruction in ID (branch taken/mispredict from EX)
- clr_cnt  in  1  synchronous clear of stall_cnt
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- issue  out  1  instruction in ID advances this cycle
- busy  out  16  busy[r] = 1 when cnt[r] != 0
- idle  out  1  no pending hazards (all counters zero)
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- State: cnt[r] (CNT_W bits) for r = 1..15. cnt[0] is constant 0 and never loaded.
- Hazard terms, all computed from registered cnt:
  - h1 = id_src1_en & (cnt[id_src1] != 0)
  - h2 = id_src2_en & (cnt[id_src2] != 0)
  - hw = id_wr_en & (id_dst != 0) & (cnt[id_dst] > id_lat). This is the WAW guard that keeps write order.
- Stall and issue:
  - stall = id_valid & ~flush & (h1 | h2 | hw)
  - issue = id_valid & ~flush & ~stall
- Counter update each clock edge:
  - If issue & id_wr_en & (id_dst != 0): cnt[id_dst] <= id_lat.
  - Every other nonzero counter decrements by 1.
  - Load takes precedence over decrement on the same register.
  - A stalled or flushed instruction loads nothing.
- Source equal to destination (e.g. r3 = r3 + 1) checks the old cnt, then loads.
- Both sources naming the same busy register give a single stall, not two.
- Sources naming register 0 never stall.
- stall_cnt:
  - clr_cnt = 1 sets it to 0. Clear beats increment.
  - Otherwise it increments on each cycle with stall = 1.
  - It saturates at all-ones and never wraps.
- idle = ~|busy.

## Timing
- stall and issue are combinational from the ID inputs and registered cnt, valid in the same cycle. They have no dependency on the register-file write port.
- A load issued at cycle t with id_lat = 1 gives cnt = 1 at t+1. A dependent instruction in ID at t+1 stalls exactly 1 cycle and issues at t+2.
- id_lat = 0 never causes a stall; the consumer issues back-to-back.
- id_lat = 3 produces stalls at t+1..t+3 for an immediate consumer. A consumer that arrives later stalls only for the remaining count.
- flush has priority over stall: a flushed cycle has stall = 0, issue = 0, and stall_cnt does not increment.
- Reset (rst_n low, asynchronous):
  - all cnt = 0, stall_cnt = 0
  - busy = 0, idle = 1
  - stall and issue forced to 0 while rst_n is low
- Reset asserted mid-stall drops all pending hazards immediately. After release, the first cycle evaluates with cleared counters.
- One issue per cycle maximum; no bypass path from this cycle's issue to this cycle's hazard check.

## Test plan
- Reset: hold rst_n = 0 with id_valid = 1 and arbitrary IDs -> stall = 0, issue = 0, busy = 0x0000, idle = 1, stall_cnt = 0; release -> first instruction issues.
- Load-use: issue load r4 (id_lat = 1), next cycle add r5 = r4 + r2 -> stall = 1 for one cycle, busy = 0x0010, issue at third cycle, stall_cnt = 1.
- ALU back-to-back and r0: issue ALU r6 (id_lat = 0), then a consumer of r6 -> no stall. Issue a write to r0 with id_lat = 3 -> busy stays 0, and readers of r0 never stall.
- Flush priority: load r7 (lat 1), then a consumer of r7 with flush = 1 -> stall = 0, issue = 0, stall_cnt unchanged, and cnt[7] still counts down to 0.
- Long latency and WAW: issue r8 with id_lat = 3, then immediately a writer of r8 with id_lat = 0 -> stalls until cnt[8] = 0 (3 cycles), then issues; idle = 1 only once all counters reach 0.
- Counter saturation and clear: force 65540 stall cycles -> stall_cnt = 0xFFFF; clr_cnt together with stall -> 0 on the next edge.
